// File: rtl/sa_pkg.sv
// Shared types and default sizing for the systolic-array sequencer.
package sa_pkg;

    localparam int SA_N      = 4;
    localparam int SA_K_W    = 8;
    localparam int ROW_W     = $clog2(SA_N);
    localparam int DRAIN_CYC = 2 * SA_N;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CLEAR   = 3'd1,
        ST_FEED    = 3'd2,
        ST_DRAIN   = 3'd3,
        ST_READOUT = 3'd4,
        ST_DONE    = 3'd5
    } sa_state_e;

endpackage

// File: rtl/sa_ctrl_if.sv
// Job-control / array-side signal bundle for sa_ctrl; slave = sequencer side.
// Carries I_ACC only when SA_CTRL_ACC_EN is defined.
interface sa_ctrl_if #(
    parameter int N   = 4,
    parameter int K_W = 8
);
    logic                   I_START;
    logic [K_W-1:0]         I_K;
    logic                   I_OUT_RDY;
`ifdef SA_CTRL_ACC_EN
    logic                   I_ACC;
`endif
    logic                   O_BUSY;
    logic                   O_DONE;
    logic                   O_PE_CLR;
    logic                   O_RD_EN;
    logic [K_W-1:0]         O_RD_ADDR;
    logic [N-1:0]           O_LANE_VLD;
    logic                   O_OUT_VLD;
    logic [$clog2(N)-1:0]   O_OUT_ROW;

    modport slave (
        input  I_START, I_K, I_OUT_RDY,
`ifdef SA_CTRL_ACC_EN
        input  I_ACC,
`endif
        output O_BUSY, O_DONE, O_PE_CLR, O_RD_EN, O_RD_ADDR,
        output O_LANE_VLD, O_OUT_VLD, O_OUT_ROW
    );

    modport master (
        output I_START, I_K, I_OUT_RDY,
`ifdef SA_CTRL_ACC_EN
        output I_ACC,
`endif
        input  O_BUSY, O_DONE, O_PE_CLR, O_RD_EN, O_RD_ADDR,
        input  O_LANE_VLD, O_OUT_VLD, O_OUT_ROW
    );
endinterface

// File: rtl/sa_vld_skew.sv
// Delay line turning the shared read enable into per-lane skewed valids:
// o_lane[i] is i_in delayed by RD_LAT + i cycles.
module sa_vld_skew #(
    parameter int N      = 4,
    parameter int RD_LAT = 1
) (
    input  logic         I_CLK,
    input  logic         I_SYNC_RST,
    input  logic         i_in,
    output logic [N-1:0] o_lane
);
    localparam int LEN = RD_LAT + N - 1;

    logic [LEN-1:0] r_sh;

    always_ff @(posedge I_CLK) begin
        if (I_SYNC_RST) begin
            r_sh <= '0;
        end else begin
            r_sh <= {r_sh[LEN-2:0], i_in};
        end
    end

    assign o_lane = r_sh[LEN-1:RD_LAT-1];
endmodule

// File: rtl/sa_ctrl.sv
// Systolic-array job sequencer: clear, operand feed, drain, row readout, done.
// SA_CTRL_ACC_EN adds I_ACC, which skips the accumulator clear for K-tiling.
module sa_ctrl
    import sa_pkg::*;
#(
    parameter int N      = SA_N,
    parameter int K_W    = SA_K_W,
    parameter int RD_LAT = 1
) (
    input  logic      I_CLK,
    input  logic      I_SYNC_RST,
    sa_ctrl_if.slave  io
);
    localparam int L_ROW_W = $clog2(N);
    localparam int L_DR_W  = $clog2(2 * N);
    localparam logic [L_DR_W-1:0]  DR_LAST  = L_DR_W'(2 * N - 1);
    localparam logic [L_ROW_W-1:0] ROW_LAST = L_ROW_W'(N - 1);

    sa_state_e            r_state;
    logic [K_W-1:0]       r_klen;
    logic [K_W-1:0]       r_cnt;
    logic [L_DR_W-1:0]    r_drain;
    logic [L_ROW_W-1:0]   r_row;

    logic                 w_feed;
    logic                 w_readout;
    logic                 w_skip_clr;
    logic [N-1:0]         w_lane;

`ifdef SA_CTRL_ACC_EN
    assign w_skip_clr = io.I_ACC;
`else
    assign w_skip_clr = 1'b0;
`endif

    always_ff @(posedge I_CLK) begin
        if (I_SYNC_RST) begin
            r_state <= ST_IDLE;
            r_klen  <= '0;
            r_cnt   <= '0;
            r_drain <= '0;
            r_row   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (io.I_START) begin
                        r_cnt <= '0;
                        if (io.I_K == '0) begin
                            r_state <= ST_DONE;
                        end else begin
                            r_klen  <= io.I_K;
                            r_state <= w_skip_clr ? ST_FEED : ST_CLEAR;
                        end
                    end
                end
                ST_CLEAR: r_state <= ST_FEED;
                ST_FEED: begin
                    if (r_cnt == r_klen - K_W'(1)) begin
                        r_cnt   <= '0;
                        r_drain <= '0;
                        r_state <= ST_DRAIN;
                    end else begin
                        r_cnt <= r_cnt + K_W'(1);
                    end
                end
                // Long enough for read latency, edge skew, PE hops to the far corner and one accumulate.
                ST_DRAIN: begin
                    if (r_drain == DR_LAST) begin
                        r_drain <= '0;
                        r_row   <= '0;
                        r_state <= ST_READOUT;
                    end else begin
                        r_drain <= r_drain + L_DR_W'(1);
                    end
                end
                ST_READOUT: begin
                    if (io.I_OUT_RDY) begin
                        if (r_row == ROW_LAST) begin
                            r_row   <= '0;
                            r_state <= ST_DONE;
                        end else begin
                            r_row <= r_row + L_ROW_W'(1);
                        end
                    end
                end
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign w_feed    = (r_state == ST_FEED);
    assign w_readout = (r_state == ST_READOUT);

    sa_vld_skew #(
        .N      (N),
        .RD_LAT (RD_LAT)
    ) u_skew (
        .I_CLK      (I_CLK),
        .I_SYNC_RST (I_SYNC_RST),
        .i_in       (w_feed),
        .o_lane     (w_lane)
    );

    assign io.O_BUSY     = (r_state != ST_IDLE);
    assign io.O_DONE     = (r_state == ST_DONE);
    assign io.O_PE_CLR   = (r_state == ST_CLEAR);
    assign io.O_RD_EN    = w_feed;
    assign io.O_RD_ADDR  = w_feed ? r_cnt : '0;
    assign io.O_LANE_VLD = w_lane;
    assign io.O_OUT_VLD  = w_readout;
    assign io.O_OUT_ROW  = w_readout ? r_row : '0;
endmodule

// File: tb/tb_sa_ctrl.sv
// Directed bench for sa_ctrl (N=4, K_W=8); per-cycle expected outputs go through a scoreboard queue.
// The I_ACC jobs only run when SA_CTRL_ACC_EN is defined.
module tb_sa_ctrl;

    typedef struct packed {
        logic       busy;
        logic       done;
        logic       clr;
        logic       rd_en;
        logic [7:0] addr;
        logic [3:0] lane;
        logic       out_vld;
        logic [1:0] row;
    } obs_t;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;
    obs_t exp_q[$];

    always #5 clk = ~clk;

    sa_ctrl_if #(.N(4), .K_W(8)) ifc ();

    sa_ctrl #(.N(4), .K_W(8), .RD_LAT(1)) dut (
        .I_CLK      (clk),
        .I_SYNC_RST (rst),
        .io         (ifc)
    );

    function automatic obs_t sample();
        obs_t o;
        o.busy    = ifc.O_BUSY;
        o.done    = ifc.O_DONE;
        o.clr     = ifc.O_PE_CLR;
        o.rd_en   = ifc.O_RD_EN;
        o.addr    = ifc.O_RD_ADDR;
        o.lane    = ifc.O_LANE_VLD;
        o.out_vld = ifc.O_OUT_VLD;
        o.row     = ifc.O_OUT_ROW;
        return o;
    endfunction

    function automatic bit feed_at(input int t, input int k, input int o);
        return (k > 0) && (t >= 1 + o) && (t <= k + o);
    endfunction

    task automatic compare(input string tag);
        obs_t e;
        obs_t o;
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $error("FAIL %s scoreboard empty", tag);
        end else begin
            e = exp_q.pop_front();
            o = sample();
            assert (o === e) else begin
                failures++;
                $error("FAIL %s observed=%h expected=%h", tag, o, e);
            end
        end
    endtask

    // Cycle t=0 carries the accepted start; xa/xb are extra start pulses, rst_at a reset cycle (-1 = none).
    task automatic run_job(input string name, input int k, input bit acc,
                           input int st_lo, input int st_hi, input int ncyc,
                           input int xa, input int xb, input int rst_at);
        int   o        = acc ? 0 : 1;
        int   ro_start = k + o + 8 + 1;
        int   done_at  = (k == 0) ? 1 : -1;
        int   row      = 0;
        bit   ro_done  = 1'b0;
        bit   rdy;
        bit   dead;
        obs_t e;
        for (int t = 0; t < ncyc; t++) begin
            @(posedge clk);
            #1;
            rst           = (t == rst_at);
            ifc.I_START   = (t == 0) || (t == xa) || (t == xb);
            ifc.I_K       = 8'(k);
`ifdef SA_CTRL_ACC_EN
            ifc.I_ACC     = acc;
`endif
            rdy           = !(t >= st_lo && t <= st_hi);
            ifc.I_OUT_RDY = rdy;
            dead          = (rst_at >= 0) && (t > rst_at);
            e = '0;
            if (!dead) begin
                e.busy  = (t >= 1) && (done_at < 0 || t <= done_at);
                e.done  = (t == done_at);
                e.clr   = (k > 0) && (o == 1) && (t == 1);
                e.rd_en = feed_at(t, k, o);
                e.addr  = e.rd_en ? 8'(t - 1 - o) : 8'd0;
                for (int i = 0; i < 4; i++) e.lane[i] = feed_at(t - 1 - i, k, o);
                if (k > 0 && !ro_done && t >= ro_start) begin
                    e.out_vld = 1'b1;
                    e.row     = 2'(row);
                    if (rdy) begin
                        if (row == 3) begin
                            ro_done = 1'b1;
                            done_at = t + 1;
                        end else begin
                            row++;
                        end
                    end
                end
            end
            exp_q.push_back(e);
            @(negedge clk);
            compare($sformatf("%s t=%0d", name, t));
        end
        ifc.I_START = 1'b0;
        rst         = 1'b0;
    endtask

    initial begin
        rst           = 1'b1;
        ifc.I_START   = 1'b0;
        ifc.I_K       = '0;
        ifc.I_OUT_RDY = 1'b0;
`ifdef SA_CTRL_ACC_EN
        ifc.I_ACC     = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.push_back('0);
        @(negedge clk);
        compare("reset_state");

        run_job("k3_basic",    3, 1'b0, -1, -1, 19, -1, -1, -1);
        run_job("k3_stall",    3, 1'b0, 14, 16, 22, -1, -1, -1);
        run_job("k3_ign_start", 3, 1'b0, -1, -1, 18,  5, 17, -1);
        run_job("k3_after_done", 3, 1'b0, -1, -1, 19, -1, -1, -1);
        run_job("k0",          0, 1'b0, -1, -1,  4, -1, -1, -1);
        run_job("k8_reset",    8, 1'b0, -1, -1,  8, -1, -1,  3);
        run_job("k3_post_rst", 3, 1'b0, -1, -1, 19, -1, -1, -1);
        run_job("k1",          1, 1'b0, 15, 15, 19, -1, -1, -1);
        run_job("k255",      255, 1'b0, -1, -1, 272, -1, -1, -1);
`ifdef SA_CTRL_ACC_EN
        run_job("k3_acc1",     3, 1'b1, -1, -1, 18, -1, -1, -1);
        run_job("k3_acc0",     3, 1'b0, -1, -1, 19, -1, -1, -1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
